// File: rtl/joypad_serializer_if.sv
// Bundle of signals between the NES core and the controller-port serializer.
// The master side (the core) drives strobe, port clocks and button inputs; the slave side returns the serial data.
interface joypad_serializer_if #(
    parameter int NUM_PORTS = 2,
    parameter int BITS      = 8
);
    logic                      joypad_strobe;
    logic [NUM_PORTS-1:0]      joypad_clock;
    logic [NUM_PORTS*BITS-1:0] pad_state;
    logic [NUM_PORTS*BITS-1:0] turbo_mask;
    logic [NUM_PORTS-1:0]      joypad_data;
    logic [NUM_PORTS-1:0]      shift_done;
    logic                      turbo_phase;

    modport master (
        output joypad_strobe, joypad_clock, pad_state, turbo_mask,
        input  joypad_data, shift_done, turbo_phase
    );

    modport slave (
        input  joypad_strobe, joypad_clock, pad_state, turbo_mask,
        output joypad_data, shift_done, turbo_phase
    );
endinterface

// File: rtl/joypad_serializer.sv
// N-port, B-bit controller shift chains with a fill value, per-port exhaustion flags and turbo auto-fire.
// The strobe reloads every port; a falling edge on a port clock shifts that port toward bit 0.
module joypad_serializer #(
    parameter int   NUM_PORTS    = 2,
    parameter int   BITS         = 8,
    parameter logic FILL         = 1'b1,
    parameter int   TURBO_PERIOD = 2
) (
    input logic                  clk,
    input logic                  reset_n,
    input logic                  ce,
    joypad_serializer_if.slave   bus
);
    localparam int CNT_W  = $clog2(BITS + 1);
    localparam int TCNT_W = (TURBO_PERIOD > 1) ? $clog2(TURBO_PERIOD) : 1;

    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(BITS);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TURBO_PERIOD - 1);
    localparam logic [TCNT_W-1:0] TCNT_ONE  = TCNT_W'(1);

    logic [BITS-1:0]      r_shift [NUM_PORTS];
    logic [CNT_W-1:0]     r_cnt   [NUM_PORTS];
    logic [NUM_PORTS-1:0] r_last_clk;
    logic                 r_last_strobe;
    logic [TCNT_W-1:0]    r_tcnt;
    logic                 r_turbo_phase;

    logic [BITS-1:0]      w_eff [NUM_PORTS];
    logic [NUM_PORTS-1:0] w_data;
    logic [NUM_PORTS-1:0] w_done;
    logic                 w_strobe_fall;

    // Turbo-masked buttons read as released during the off phase.
    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            w_eff[p] = bus.pad_state[p*BITS +: BITS]
                     & ~(bus.turbo_mask[p*BITS +: BITS] & {BITS{~r_turbo_phase}});
        end
    end

    assign w_strobe_fall = r_last_strobe & ~bus.joypad_strobe;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: the shift array is reset per element because a reset mid-read must discard the latched buttons.
            for (int p = 0; p < NUM_PORTS; p++) begin
                r_shift[p] <= '0;
                r_cnt[p]   <= '0;
            end
            r_last_clk    <= '0;
            r_last_strobe <= 1'b0;
            r_tcnt        <= '0;
            r_turbo_phase <= 1'b1;
        end else if (ce) begin
            // NOTE: non-blocking assignments so every port and the edge history see pre-edge values.
            r_last_clk    <= bus.joypad_clock;
            r_last_strobe <= bus.joypad_strobe;

            for (int p = 0; p < NUM_PORTS; p++) begin
                if (bus.joypad_strobe) begin
                    r_shift[p] <= w_eff[p];
                    r_cnt[p]   <= '0;
                end else if (r_last_clk[p] && !bus.joypad_clock[p]) begin
                    r_shift[p] <= {FILL, r_shift[p][BITS-1:1]};
                    if (r_cnt[p] != CNT_MAX) begin
                        r_cnt[p] <= r_cnt[p] + CNT_ONE;
                    end
                end
            end

            if (w_strobe_fall) begin
                if (r_tcnt == TCNT_LAST) begin
                    r_tcnt        <= '0;
                    r_turbo_phase <= ~r_turbo_phase;
                end else begin
                    r_tcnt <= r_tcnt + TCNT_ONE;
                end
            end
        end
    end

    // NOTE: defaults first so no path through this block can infer a latch.
    always_comb begin
        w_data = '0;
        w_done = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            w_data[p] = r_shift[p][0];
            w_done[p] = (r_cnt[p] == CNT_MAX);
        end
    end

    assign bus.joypad_data = w_data;
    assign bus.shift_done  = w_done;
    assign bus.turbo_phase = r_turbo_phase;
endmodule

// File: tb/tb_joypad_serializer.sv
// Bench for joypad_serializer: an 8-bit/fill-1/turbo-2 instance and a 16-bit/fill-0/turbo-3 instance,
// checked every cycle against a model that tracks latched value, shift count and strobe-fall count.
module tb_joypad_serializer;
    localparam int   A_PORTS = 2;
    localparam int   A_BITS  = 8;
    localparam int   A_TP    = 2;
    localparam logic A_FILL  = 1'b1;
    localparam int   B_PORTS = 2;
    localparam int   B_BITS  = 16;
    localparam int   B_TP    = 3;
    localparam logic B_FILL  = 1'b0;

    logic        clk;
    logic        reset_n;
    logic        ce;
    logic        in_stb  [2];
    logic [1:0]  in_jclk [2];
    logic [31:0] in_pad  [2];
    logic [31:0] in_mask [2];

    int checks   = 0;
    int failures = 0;

    // Model: value captured at the last reload, number of falling edges since, strobe falls since reset.
    logic [31:0] m_lat  [2][2];
    int          m_k    [2][2];
    logic [1:0]  m_lclk [2];
    logic        m_lstb [2];
    int          m_n    [2];

    joypad_serializer_if #(.NUM_PORTS(A_PORTS), .BITS(A_BITS)) bus_a ();
    joypad_serializer_if #(.NUM_PORTS(B_PORTS), .BITS(B_BITS)) bus_b ();

    assign bus_a.joypad_strobe = in_stb[0];
    assign bus_a.joypad_clock  = in_jclk[0];
    assign bus_a.pad_state     = in_pad[0][A_PORTS*A_BITS-1:0];
    assign bus_a.turbo_mask    = in_mask[0][A_PORTS*A_BITS-1:0];
    assign bus_b.joypad_strobe = in_stb[1];
    assign bus_b.joypad_clock  = in_jclk[1];
    assign bus_b.pad_state     = in_pad[1];
    assign bus_b.turbo_mask    = in_mask[1];

    joypad_serializer #(.NUM_PORTS(A_PORTS), .BITS(A_BITS), .FILL(A_FILL), .TURBO_PERIOD(A_TP)) u_dut_a (
        .clk     (clk),
        .reset_n (reset_n),
        .ce      (ce),
        .bus     (bus_a)
    );

    joypad_serializer #(.NUM_PORTS(B_PORTS), .BITS(B_BITS), .FILL(B_FILL), .TURBO_PERIOD(B_TP)) u_dut_b (
        .clk     (clk),
        .reset_n (reset_n),
        .ce      (ce),
        .bus     (bus_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int bits_of(input int i);
        return (i == 0) ? A_BITS : B_BITS;
    endfunction

    function automatic int tp_of(input int i);
        return (i == 0) ? A_TP : B_TP;
    endfunction

    function automatic logic fill_of(input int i);
        return (i == 0) ? A_FILL : B_FILL;
    endfunction

    // Phase starts at 1 and flips after every TURBO_PERIOD strobe falls.
    function automatic logic model_phase(input int i);
        return ((m_n[i] / tp_of(i)) % 2) == 0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            for (int p = 0; p < 2; p++) begin
                m_lat[i][p] = '0;
                m_k[i][p]   = 0;
            end
            m_lclk[i] = '0;
            m_lstb[i] = 1'b0;
            m_n[i]    = 0;
        end
    endtask

    task automatic model_tick();
        for (int i = 0; i < 2; i++) begin
            int          b;
            logic        ph;
            logic [31:0] keep;
            logic [31:0] pv;
            logic [31:0] mv;
            b    = bits_of(i);
            ph   = model_phase(i);
            keep = (32'd1 << b) - 32'd1;
            for (int p = 0; p < 2; p++) begin
                pv = (in_pad[i] >> (p * b)) & keep;
                mv = (in_mask[i] >> (p * b)) & keep;
                if (in_stb[i]) begin
                    m_lat[i][p] = ph ? pv : (pv & ~mv);
                    m_k[i][p]   = 0;
                end else if (m_lclk[i][p] && !in_jclk[i][p]) begin
                    m_k[i][p] = m_k[i][p] + 1;
                end
            end
            if (m_lstb[i] && !in_stb[i]) m_n[i] = m_n[i] + 1;
            m_lclk[i] = in_jclk[i];
            m_lstb[i] = in_stb[i];
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 2; i++) begin
            int         b;
            string      nm;
            logic [1:0] exp_d;
            logic [1:0] exp_s;
            logic [1:0] obs_d;
            logic [1:0] obs_s;
            logic       obs_ph;
            b  = bits_of(i);
            nm = (i == 0) ? "A" : "B";
            for (int p = 0; p < 2; p++) begin
                exp_d[p] = (m_k[i][p] < b) ? m_lat[i][p][m_k[i][p]] : fill_of(i);
                exp_s[p] = (m_k[i][p] >= b);
            end
            obs_d  = (i == 0) ? bus_a.joypad_data : bus_b.joypad_data;
            obs_s  = (i == 0) ? bus_a.shift_done  : bus_b.shift_done;
            obs_ph = (i == 0) ? bus_a.turbo_phase : bus_b.turbo_phase;
            check({nm, ".data"},  32'(obs_d),  32'(exp_d));
            check({nm, ".done"},  32'(obs_s),  32'(exp_s));
            check({nm, ".phase"}, 32'(obs_ph), 32'(model_phase(i)));
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (!reset_n) model_reset();
        else if (ce) model_tick();
        #1;
        check_all();
    endtask

    task automatic pulse(input int i, input int p);
        in_jclk[i][p] = 1'b1;
        step();
        in_jclk[i][p] = 1'b0;
        step();
    endtask

    task automatic strobe_pulse(input int i);
        in_stb[i] = 1'b1;
        step();
        in_stb[i] = 1'b0;
        step();
    endtask

    initial begin
        logic [9:0]  seq;
        logic [15:0] pv;
        logic [3:0]  turbo_exp;
        logic [3:0]  phase_exp;

        reset_n = 1'b0;
        ce      = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_stb[i]  = 1'b0;
            in_jclk[i] = '0;
            in_pad[i]  = '0;
            in_mask[i] = '0;
        end
        model_reset();

        // Reset state and idle.
        step();
        check("rst.a_data",  32'(bus_a.joypad_data), 32'd0);
        check("rst.a_done",  32'(bus_a.shift_done),  32'd0);
        check("rst.a_phase", 32'(bus_a.turbo_phase), 32'd1);
        step();
        reset_n = 1'b1;
        repeat (3) step();

        // Port0 = 8'b1000_0001, nine falling edges; the last two read FILL.
        in_pad[0] = 32'h0000_0081;
        strobe_pulse(0);
        seq = 10'b11_1000_0001;
        check("a.seq", 32'(bus_a.joypad_data[0]), 32'(seq[0]));
        for (int j = 1; j <= 9; j++) begin
            pulse(0, 0);
            check("a.seq",  32'(bus_a.joypad_data[0]), 32'(seq[j]));
            check("a.sdone", 32'(bus_a.shift_done[0]), 32'(j >= 8));
        end

        // 16-bit pads: clocks on port1 only, port0 must hold.
        in_pad[1] = 32'h00F0_FFFF;
        strobe_pulse(1);
        pv = 16'h00F0;
        for (int j = 0; j < 16; j++) begin
            check("b.p1", 32'(bus_b.joypad_data[1]), 32'(pv[j]));
            pulse(1, 1);
        end
        check("b.p1_done", 32'(bus_b.shift_done[1]), 32'd1);
        check("b.p0_data", 32'(bus_b.joypad_data[0]), 32'd1);
        check("b.p0_done", 32'(bus_b.shift_done[0]), 32'd0);

        // Strobe wins over a falling clock; live pad tracking while strobe is high.
        in_pad[0] = 32'h0000_0002;
        in_stb[0] = 1'b1;
        step();
        pulse(0, 0);
        check("a.sw_done", 32'(bus_a.shift_done[0]), 32'd0);
        check("a.sw_data", 32'(bus_a.joypad_data[0]), 32'd0);
        in_pad[0] = 32'h0000_0003;
        step();
        check("a.live", 32'(bus_a.joypad_data[0]), 32'd1);
        in_stb[0] = 1'b0;
        step();

        // Turbo from a clean reset: bit0 masked, phase flips after the 2nd strobe fall.
        reset_n = 1'b0;
        model_reset();
        #1;
        check_all();
        step();
        reset_n = 1'b1;
        step();
        in_pad[0]  = 32'h0000_0001;
        in_mask[0] = 32'h0000_0001;
        turbo_exp  = 4'b0011;
        phase_exp  = 4'b1001;
        for (int t = 0; t < 4; t++) begin
            in_stb[0] = 1'b1;
            step();
            step();
            check("a.turbo", 32'(bus_a.joypad_data[0]), 32'(turbo_exp[t]));
            in_stb[0] = 1'b0;
            step();
            check("a.tphase", 32'(bus_a.turbo_phase), 32'(phase_exp[t]));
        end
        in_mask[0] = '0;

        // Reset mid-shift: outputs clear without a clock, then FILL needs BITS shifts to reach bit 0.
        in_pad[0] = 32'h0000_00FF;
        strobe_pulse(0);
        repeat (3) pulse(0, 0);
        reset_n = 1'b0;
        model_reset();
        #1;
        check("mid.data",  32'(bus_a.joypad_data), 32'd0);
        check("mid.done",  32'(bus_a.shift_done),  32'd0);
        check("mid.phase", 32'(bus_a.turbo_phase), 32'd1);
        step();
        reset_n = 1'b1;
        step();
        for (int j = 1; j <= 8; j++) begin
            pulse(0, 0);
            check("a.post_rst", 32'(bus_a.joypad_data[0]), 32'(j == 8));
        end

        // ce=0 freezes edge history; the falling edge is seen once ce returns.
        in_jclk[0][1] = 1'b1;
        step();
        ce = 1'b0;
        in_jclk[0][1] = 1'b0;
        step();
        step();
        ce = 1'b1;
        step();

        // Randomised traffic against the model.
        for (int n = 0; n < 1500; n++) begin
            ce = ($urandom_range(0, 7) != 0);
            for (int i = 0; i < 2; i++) begin
                in_stb[i]  = ($urandom_range(0, 15) == 0);
                in_jclk[i] = 2'($urandom);
                if ($urandom_range(0, 7) == 0) in_pad[i]  = $urandom;
                if ($urandom_range(0, 31) == 0) in_mask[i] = $urandom;
            end
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
